// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: control polarities,
// data-memory FSM state encoding and the default access timeout.
package pipeline_ctrl_pkg;

   localparam logic STOP     = 1'b1;
   localparam logic NOT_STOP = 1'b0;
   localparam logic FLUSH    = 1'b1;
   localparam logic NO_FLUSH = 1'b0;

   localparam int DEF_MEM_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FAULT = 2'd2
   } mem_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Status/control bundle between the datapath and pipeline_ctrl. The perf counter
// outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int PERF_W     = 32
);
   import pipeline_ctrl_pkg::*;

   logic [REG_ADDR_W-1:0] id_rs1_addr;
   logic [REG_ADDR_W-1:0] id_rs2_addr;
   logic                  id_rs1_rd;
   logic                  id_rs2_rd;
   logic                  ex_isload;
   logic                  ex_wr_bck_en;
   logic [REG_ADDR_W-1:0] ex_wr_reg_addr;
   logic                  ex_branch_taken;
   logic                  mem_access;
   logic                  dmem_ack;

   logic                  dmem_req;
   logic                  stall_pc;
   logic                  stall_if_id;
   logic                  stall_id_ex;
   logic                  stall_ex_mem;
   logic                  flush_if_id;
   logic                  flush_id_ex;
   logic                  flush_mem_wb;
   logic                  mem_fault;
   mem_state_t            dbg_state;
`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0]     perf_mem_stall_cnt;
   logic [PERF_W-1:0]     perf_lu_cnt;
   logic [PERF_W-1:0]     perf_flush_cnt;
`endif

   // Controller side: consumes datapath status, drives register controls.
   modport master (
      input  id_rs1_addr, id_rs2_addr, id_rs1_rd, id_rs2_rd,
      input  ex_isload, ex_wr_bck_en, ex_wr_reg_addr, ex_branch_taken,
      input  mem_access, dmem_ack,
      output dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
      output flush_if_id, flush_id_ex, flush_mem_wb, mem_fault, dbg_state
`ifdef PIPE_CTRL_PERF_EN
      , output perf_mem_stall_cnt, perf_lu_cnt, perf_flush_cnt
`endif
   );

   modport slave (
      output id_rs1_addr, id_rs2_addr, id_rs1_rd, id_rs2_rd,
      output ex_isload, ex_wr_bck_en, ex_wr_reg_addr, ex_branch_taken,
      output mem_access, dmem_ack,
      input  dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
      input  flush_if_id, flush_id_ex, flush_mem_wb, mem_fault, dbg_state
`ifdef PIPE_CTRL_PERF_EN
      , input perf_mem_stall_cnt, perf_lu_cnt, perf_flush_cnt
`endif
   );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard: the ID instruction reads the register a load in EX is about
// to write. x0 never creates a hazard.
module pipeline_ctrl_load_use_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_rs1_rd,
   input  logic                  id_rs2_rd,
   input  logic                  ex_isload,
   input  logic                  ex_wr_bck_en,
   input  logic [REG_ADDR_W-1:0] ex_wr_reg_addr,
   output logic                  lu
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_rs1_rd && (id_rs1_addr == ex_wr_reg_addr);
   assign rs2_hit = id_rs2_rd && (id_rs2_addr == ex_wr_reg_addr);
   assign lu      = ex_isload && ex_wr_bck_en && (ex_wr_reg_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: data-memory wait FSM, branch squash and
// load-use bubble. Define PIPE_CTRL_PERF_EN to add saturating perf counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int TO_CNT_W    = 8,
   parameter int PERF_W      = 32
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.master bus
);

   localparam logic [TO_CNT_W-1:0] TIMEOUT_C = TO_CNT_W'(MEM_TIMEOUT);

   if (((2 ** TO_CNT_W) <= MEM_TIMEOUT) || (MEM_TIMEOUT < 1) || (PERF_W < 1)) begin : g_bad_cfg
      $error("pipeline_ctrl: inconsistent MEM_TIMEOUT/TO_CNT_W/PERF_W");
   end

   mem_state_t          state_q, state_d;
   logic [TO_CNT_W-1:0] cnt_q, cnt_d;
   logic                mem_stall;
   logic                req;
   logic                lu;
   logic                branch_flush;
   logic                lu_bubble;

   pipeline_ctrl_load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
      .id_rs1_addr   (bus.id_rs1_addr),
      .id_rs2_addr   (bus.id_rs2_addr),
      .id_rs1_rd     (bus.id_rs1_rd),
      .id_rs2_rd     (bus.id_rs2_rd),
      .ex_isload     (bus.ex_isload),
      .ex_wr_bck_en  (bus.ex_wr_bck_en),
      .ex_wr_reg_addr(bus.ex_wr_reg_addr),
      .lu            (lu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The FSM looks only at dmem_ack and the timeout; mem_access dropping
   // mid-wait is treated as no ack.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_stall = NOT_STOP;
      req       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req = bus.mem_access;
            if (bus.mem_access && !bus.dmem_ack) begin
               state_d   = ST_WAIT;
               mem_stall = STOP;
            end
         end
         ST_WAIT: begin
            req = 1'b1;
            if (bus.dmem_ack) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               mem_stall = (cnt_q < TIMEOUT_C) ? STOP : NOT_STOP;
               cnt_d     = cnt_q + TO_CNT_W'(1);
               if (cnt_d >= TIMEOUT_C) state_d = ST_FAULT;
            end
         end
         ST_FAULT: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (rst) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         mem_stall = NOT_STOP;
         req       = 1'b0;
      end
   end

   // A held branch is re-presented after the memory stall releases; the branch
   // squashes the ID instruction, so it overrides a load-use bubble.
   assign branch_flush = bus.ex_branch_taken && !mem_stall && !rst;
   assign lu_bubble    = lu && !mem_stall && !bus.ex_branch_taken && !rst;

   always_comb begin
      bus.dmem_req     = req;
      bus.stall_pc     = (mem_stall || lu_bubble) ? STOP : NOT_STOP;
      bus.stall_if_id  = (mem_stall || lu_bubble) ? STOP : NOT_STOP;
      bus.stall_id_ex  = mem_stall ? STOP : NOT_STOP;
      bus.stall_ex_mem = mem_stall ? STOP : NOT_STOP;
      bus.flush_if_id  = branch_flush ? FLUSH : NO_FLUSH;
      bus.flush_id_ex  = (branch_flush || lu_bubble) ? FLUSH : NO_FLUSH;
      bus.flush_mem_wb = mem_stall ? FLUSH : NO_FLUSH;
      bus.mem_fault    = (state_q == ST_FAULT) && !rst;
      bus.dbg_state    = state_q;
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] perf_ms_q, perf_ms_d;
   logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
   logic [PERF_W-1:0] perf_fl_q, perf_fl_d;

   always_comb begin
      perf_ms_d = perf_ms_q;
      perf_lu_d = perf_lu_q;
      perf_fl_d = perf_fl_q;
      if (mem_stall && (perf_ms_q != '1))    perf_ms_d = perf_ms_q + PERF_W'(1);
      if (lu_bubble && (perf_lu_q != '1))    perf_lu_d = perf_lu_q + PERF_W'(1);
      if (branch_flush && (perf_fl_q != '1)) perf_fl_d = perf_fl_q + PERF_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ms_q <= '0;
         perf_lu_q <= '0;
         perf_fl_q <= '0;
      end else begin
         perf_ms_q <= perf_ms_d;
         perf_lu_q <= perf_lu_d;
         perf_fl_q <= perf_fl_d;
      end
   end

   assign bus.perf_mem_stall_cnt = perf_ms_q;
   assign bus.perf_lu_cnt        = perf_lu_q;
   assign bus.perf_flush_cnt     = perf_fl_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic checked
// against a transaction-level model of stall/flush rules.
module tb_pipeline_ctrl;

   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipeline_ctrl_if #(.REG_ADDR_W(5), .PERF_W(32)) bus ();

   pipeline_ctrl #(
      .REG_ADDR_W (5),
      .MEM_TIMEOUT(TMO),
      .TO_CNT_W   (8),
      .PERF_W     (32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [10:0] obs;
   logic [10:0] exp_v;
   assign obs = {bus.dbg_state, bus.dmem_req, bus.stall_pc, bus.stall_if_id, bus.stall_id_ex,
                 bus.stall_ex_mem, bus.flush_if_id, bus.flush_id_ex, bus.flush_mem_wb, bus.mem_fault};

   // Model: pend = stalled cycles of the outstanding access (-1 = none).
   // An access may stall for at most TMO+1 cycles before a fault cycle.
   int   pend = -1;
   logic fault_next = 1'b0;

   function automatic logic [10:0] model_out();
      logic [1:0] st;
      logic ms, req, flt, hz, br, bub;
      st = fault_next ? 2'd2 : ((pend >= 0) ? 2'd1 : 2'd0);
      if (rst) return {st, 9'b0};
      ms = 1'b0; req = 1'b0; flt = 1'b0;
      if (fault_next) flt = 1'b1;
      else if (pend < 0) begin
         req = bus.mem_access;
         ms  = bus.mem_access && !bus.dmem_ack;
      end else begin
         req = 1'b1;
         ms  = !bus.dmem_ack;
      end
      hz  = bus.ex_isload && bus.ex_wr_bck_en && (bus.ex_wr_reg_addr != 0) &&
            ((bus.id_rs1_rd && bus.id_rs1_addr == bus.ex_wr_reg_addr) ||
             (bus.id_rs2_rd && bus.id_rs2_addr == bus.ex_wr_reg_addr));
      br  = bus.ex_branch_taken && !ms;
      bub = hz && !ms && !bus.ex_branch_taken;
      return {st, req, ms | bub, ms | bub, ms, ms, br, br | bub, ms, flt};
   endfunction

   task automatic model_step();
      if (rst) begin
         pend = -1; fault_next = 1'b0;
      end else if (fault_next) begin
         fault_next = 1'b0;
      end else if (pend < 0) begin
         if (bus.mem_access && !bus.dmem_ack) pend = 1;
      end else if (bus.dmem_ack) begin
         pend = -1;
      end else begin
         pend++;
         if (pend > TMO) begin
            pend = -1; fault_next = 1'b1;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
      exp_v = model_out();
      checks++;
   endtask

   task automatic clear_inputs();
      bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_rs1_rd = 1'b0; bus.id_rs2_rd = 1'b0;
      bus.ex_isload = 1'b0; bus.ex_wr_bck_en = 1'b0; bus.ex_wr_reg_addr = '0;
      bus.ex_branch_taken = 1'b0; bus.mem_access = 1'b0; bus.dmem_ack = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1);
      bus.ex_isload = 1'b1; bus.ex_wr_bck_en = 1'b1; bus.ex_wr_reg_addr = rd;
      bus.id_rs1_rd = 1'b1; bus.id_rs1_addr = rs1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick(); tick();
      bus.mem_access = 1'b1; bus.ex_branch_taken = 1'b1;
      settle();
      if (obs !== exp_v) begin errors++; $display("FAIL reset_hold: got %b expected %b", obs, exp_v); end
      tick();
      clear_inputs();
      rst = 1'b0;
      settle();
      if (obs !== 11'b0) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs, 11'b0); end
      tick();
   endtask

   task automatic test_load_use();
      set_load_use(5'd5, 5'd5);
      settle();
      if (obs !== exp_v) begin errors++; $display("FAIL lu_bubble: got %b expected %b", obs, exp_v); end
      tick();
      clear_inputs();
      settle();
      if (obs !== exp_v) begin errors++; $display("FAIL lu_after: got %b expected %b", obs, exp_v); end
      tick();
      set_load_use(5'd0, 5'd0);
      settle();
      if (obs !== exp_v) begin errors++; $display("FAIL lu_x0: got %b expected %b", obs, exp_v); end
      tick();
      clear_inputs();
      bus.ex_isload = 1'b1; bus.ex_wr_bck_en = 1'b1; bus.ex_wr_reg_addr = 5'd9;
      bus.id_rs2_rd = 1'b1; bus.id_rs2_addr = 5'd9;
      settle();
      if (obs !== exp_v) begin errors++; $display("FAIL lu_rs2: got %b expected %b", obs, exp_v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      bus.mem_access = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.dmem_ack = (i == 3);
         settle();
         if (obs !== exp_v) begin errors++; $display("FAIL mem_wait[%0d]: got %b expected %b", i, obs, exp_v); end
         tick();
      end
      clear_inputs();
      settle();
      if (obs !== exp_v) begin errors++; $display("FAIL mem_wait_idle: got %b expected %b", obs, exp_v); end
      tick();
      bus.mem_access = 1'b1; bus.dmem_ack = 1'b1;
      settle();
      if (obs !== exp_v) begin errors++; $display("FAIL mem_single: got %b expected %b", obs, exp_v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_timeout();
      bus.mem_access = 1'b1;
      for (int i = 0; i < TMO + 4; i++) begin
         settle();
         if (obs !== exp_v) begin errors++; $display("FAIL timeout[%0d]: got %b expected %b", i, obs, exp_v); end
         tick();
         if (i == TMO + 1) bus.mem_access = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_branch_lu();
      set_load_use(5'd7, 5'd7);
      bus.ex_branch_taken = 1'b1;
      settle();
      if (obs !== exp_v) begin errors++; $display("FAIL branch_lu: got %b expected %b", obs, exp_v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_branch_wait();
      bus.mem_access = 1'b1; bus.ex_branch_taken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.dmem_ack = (i == 3);
         settle();
         if (obs !== exp_v) begin errors++; $display("FAIL branch_wait[%0d]: got %b expected %b", i, obs, exp_v); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_rst_mid_wait();
      bus.mem_access = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rst = (i == 2);
         if (i >= 3) bus.mem_access = 1'b0;
         settle();
         if (obs !== exp_v) begin errors++; $display("FAIL rst_wait[%0d]: got %b expected %b", i, obs, exp_v); end
         tick();
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst                 = ($urandom_range(0, 59) == 0);
         bus.id_rs1_addr     = 5'($urandom_range(0, 3));
         bus.id_rs2_addr     = 5'($urandom_range(0, 3));
         bus.id_rs1_rd       = 1'($urandom_range(0, 1));
         bus.id_rs2_rd       = 1'($urandom_range(0, 1));
         bus.ex_isload       = 1'($urandom_range(0, 1));
         bus.ex_wr_bck_en    = ($urandom_range(0, 3) != 0);
         bus.ex_wr_reg_addr  = 5'($urandom_range(0, 3));
         bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
         bus.mem_access      = (pend >= 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
         bus.dmem_ack        = ($urandom_range(0, 3) == 0);
         settle();
         if (obs !== exp_v) begin errors++; $display("FAIL random[%0d]: got %b expected %b", i, obs, exp_v); end
         checks++;
         if ((bus.stall_if_id && bus.flush_if_id) || (bus.stall_id_ex && bus.flush_id_ex)) begin
            errors++;
            $display("FAIL stall_flush_excl[%0d]: got %b expected no stall+flush overlap", i, obs);
         end
         tick();
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_branch_lu();
      test_branch_wait();
      test_rst_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
